usb_debug_trace: RTL

USB_DEBUG_TRACE -- requirements
Module: usb_debug_trace

---
 rtl/usb_debug_trace.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/usb_debug_trace.sv
// -----------------------------------------------------------------------------
// usb_debug_trace
//
// Single-clock logic-analyser style trace buffer for the ULPI clock domain.
// Every cycle of an active capture writes the probe word into a circular
// buffer. The trigger is qualified by a masked compare, which is either
// level- or rising-edge sensitive, or by an external strobe. A programmable
// number of pre-trigger samples is kept ahead of the trigger. The buffer is
// frozen once it holds one full window around the trigger.
//
// Ports
//   ulpi_clk     in   sample clock (rising edge)
//   ulpi_rst_n   in   asynchronous active-low reset
//   probe        in   WIDTH   signals sampled every cycle
//   arm          in   1       start capture (pulse, accepted in IDLE/DONE)
//   abort        in   1       return to IDLE, wins over arm
//   trig_mask    in   WIDTH   per-bit compare enable
//   trig_value   in   WIDTH   compare value
//   trig_edge    in   1       0 = level trigger, 1 = rising-edge trigger
//   ext_trig     in   1       external trigger, ORed into the hit
//   state        out  3       IDLE=0 FILL=1 WAIT=2 POST=3 DONE=4
//   trig_addr    out  DEPTH_LOG2  buffer address of the trigger sample
//   rd_addr      in   DEPTH_LOG2  readout address
//   rd_data      out  WIDTH   mem[rd_addr], one cycle later
// -----------------------------------------------------------------------------
module usb_debug_trace #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned PRE_TRIG   = 64
) (
    input  logic                  ulpi_clk,
    input  logic                  ulpi_rst_n,
    input  logic [WIDTH-1:0]      probe,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      trig_mask,
    input  logic [WIDTH-1:0]      trig_value,
    input  logic                  trig_edge,
    input  logic                  ext_trig,
    output logic [2:0]            state,
    output logic [DEPTH_LOG2-1:0] trig_addr,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int unsigned Depth   = 1 << DEPTH_LOG2;
    // Samples written after the trigger sample so the buffer holds exactly
    // PRE_TRIG + 1 + PostLen = Depth samples.
    localparam int unsigned PostLen = Depth - PRE_TRIG - 1;

    // Terminal counts; guarded so a zero length does not underflow. A zero
    // length never reaches its counter compare anyway.
    localparam int unsigned FillLastI = (PRE_TRIG == 0) ? 0 : PRE_TRIG - 1;
    localparam int unsigned PostLastI = (PostLen == 0) ? 0 : PostLen - 1;
    localparam logic [DEPTH_LOG2-1:0] FillLast = DEPTH_LOG2'(FillLastI);
    localparam logic [DEPTH_LOG2-1:0] PostLast = DEPTH_LOG2'(PostLastI);

    if (PRE_TRIG >= Depth) begin : g_bad_pre_trig
        $error("PRE_TRIG must be below 2**DEPTH_LOG2");
    end

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StFill = 3'd1,
        StWait = 3'd2,
        StPost = 3'd3,
        StDone = 3'd4
    } state_e;

    state_e                  state_q;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   trig_addr_q;
    logic [DEPTH_LOG2-1:0]   fill_cnt_q;
    logic [DEPTH_LOG2-1:0]   post_cnt_q;
    logic                    match_d_q;
    logic [WIDTH-1:0]        rd_data_q;
    logic [WIDTH-1:0]        mem_q [Depth];

    logic match;
    logic hit;
    logic capturing;

    // Masked compare: bits with a clear mask bit never block a match, so an
    // all-zero mask matches every sample.
    assign match     = ((probe ^ trig_value) & trig_mask) == '0;
    assign hit       = (trig_edge ? (match & ~match_d_q) : match) | ext_trig;
    assign capturing = (state_q == StFill) || (state_q == StWait) || (state_q == StPost);

    // Control FSM. The write pointer advances on every capturing cycle,
    // including the one in which abort lands, so it always points at the
    // slot of the sample being written in the current cycle.
    always_ff @(posedge ulpi_clk or negedge ulpi_rst_n) begin
        if (!ulpi_rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            trig_addr_q <= '0;
            fill_cnt_q  <= '0;
            post_cnt_q  <= '0;
            match_d_q   <= 1'b0;
        end else begin
            match_d_q <= match;

            if (abort) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (arm) begin
                            state_q    <= (PRE_TRIG == 0) ? StWait : StFill;
                            wr_ptr_q   <= '0;
                            fill_cnt_q <= '0;
                            post_cnt_q <= '0;
                            // Forget stale history so the first matching
                            // sample after arm can count as an edge.
                            match_d_q  <= 1'b0;
                        end
                    end
                    StFill: begin
                        // hit is deliberately not looked at here.
                        if (fill_cnt_q == FillLast) begin
                            state_q <= StWait;
                        end else begin
                            fill_cnt_q <= fill_cnt_q + DEPTH_LOG2'(1);
                        end
                    end
                    StWait: begin
                        if (hit) begin
                            trig_addr_q <= wr_ptr_q;
                            post_cnt_q  <= '0;
                            state_q     <= (PostLen == 0) ? StDone : StPost;
                        end
                    end
                    StPost: begin
                        if (post_cnt_q == PostLast) begin
                            state_q <= StDone;
                        end else begin
                            post_cnt_q <= post_cnt_q + DEPTH_LOG2'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end

            if (capturing) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
        end
    end

    // Sample storage; intentionally not reset so a capture survives reset
    // and abort for later readout.
    always_ff @(posedge ulpi_clk) begin
        if (capturing) begin
            mem_q[wr_ptr_q] <= probe;
        end
    end

    // Registered readout; the non-blocking write above means a same-address
    // read in the same cycle returns the previous contents.
    always_ff @(posedge ulpi_clk or negedge ulpi_rst_n) begin
        if (!ulpi_rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign state     = state_q;
    assign trig_addr = trig_addr_q;
    assign rd_data   = rd_data_q;

endmodule
